// File: rtl/shift_unit_ctrl.sv
// Shift/rotate sequencer around one 32-bit logical barrel shifter.
// Rotates are built only when SHIFT_UNIT_CTRL_ROTATE_EN is defined; otherwise ROL/ROR report an error.

module barrel_shifter (
  input  logic [31:0] din,
  input  logic [4:0]  amt,
  input  logic        dir,
  output logic [31:0] dout
);

  logic [31:0] stage [0:5];

  assign stage[0] = din;

  // One power-of-two stage per amount bit; dir 0 = left, 1 = right.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stage
      localparam int unsigned SH = 1 << gi;
      assign stage[gi+1] = !amt[gi] ? stage[gi]
                         : (dir ? (stage[gi] >> SH) : (stage[gi] << SH));
    end
  endgenerate

  assign dout = stage[5];

endmodule

module shift_unit_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_amt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_e;
  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } op_e;

  state_e      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [31:0] data_reg;
  logic [4:0]  amt_reg;
  logic [31:0] partial_reg;
  logic [31:0] result_reg;
  logic        err_reg;

  logic        op_legal;
  logic        is_rot;
  logic        two_pass;
  logic [31:0] sh_din;
  logic [4:0]  sh_amt;
  logic        sh_dir;
  logic [31:0] sh_dout;
  logic [31:0] pass2_result;

  barrel_shifter u_shifter (
    .din  (sh_din),
    .amt  (sh_amt),
    .dir  (sh_dir),
    .dout (sh_dout)
  );

`ifdef SHIFT_UNIT_CTRL_ROTATE_EN
  logic [4:0] rot_amt;
  // amt is nonzero whenever the rotate second pass runs, so 32-amt fits in 5 bits.
  assign rot_amt  = 5'(6'd32 - {1'b0, amt_reg});
  assign is_rot   = (op_reg == OP_ROL) || (op_reg == OP_ROR);
  assign op_legal = (op_reg <= OP_ROR);
`else
  assign is_rot   = 1'b0;
  assign op_legal = (op_reg <= OP_SRA);
`endif

  assign two_pass = (op_reg == OP_SRA) || (is_rot && (amt_reg != 5'd0));

  // Shifter inputs stay at zero except in the two pass states.
  always_comb begin
    sh_din = 32'd0;
    sh_amt = 5'd0;
    sh_dir = 1'b0;
    case (state_reg)
      PASS1: begin
        if (op_legal) begin
          sh_din = data_reg;
          sh_amt = amt_reg;
          sh_dir = (op_reg == OP_SRL) || (op_reg == OP_SRA) || (op_reg == OP_ROR);
        end
      end
      PASS2: begin
        if (op_reg == OP_SRA) begin
          sh_din = 32'hFFFF_FFFF;
          sh_amt = amt_reg;
          sh_dir = 1'b1;
        end
`ifdef SHIFT_UNIT_CTRL_ROTATE_EN
        else if (op_reg == OP_ROL) begin
          sh_din = data_reg;
          sh_amt = rot_amt;
          sh_dir = 1'b1;
        end else if (op_reg == OP_ROR) begin
          sh_din = data_reg;
          sh_amt = rot_amt;
          sh_dir = 1'b0;
        end
`endif
      end
      default: ;
    endcase
  end

  // SRA fills vacated high bits with the sign via the inverted all-ones mask.
  always_comb begin
    pass2_result = partial_reg | sh_dout;
    if (op_reg == OP_SRA)
      pass2_result = partial_reg | (data_reg[31] ? ~sh_dout : 32'd0);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = PASS1;
      PASS1:   state_next = two_pass ? PASS2 : DONE;
      PASS2:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= 3'd0;
      data_reg    <= 32'd0;
      amt_reg     <= 5'd0;
      partial_reg <= 32'd0;
      result_reg  <= 32'd0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg   <= in_op;
            data_reg <= in_data;
            amt_reg  <= in_amt;
          end
        end
        PASS1: begin
          partial_reg <= sh_dout;
          result_reg  <= op_legal ? sh_dout : 32'd0;
          err_reg     <= !op_legal;
        end
        PASS2: begin
          result_reg <= pass2_result;
          err_reg    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_data  = result_reg;
  assign out_err   = err_reg;

endmodule

// File: tb/tb_shift_unit_ctrl.sv
// Directed bench for shift_unit_ctrl: vector table plus throughput, backpressure and reset-abort sequences.
// Rotate vectors follow SHIFT_UNIT_CTRL_ROTATE_EN.

module tb_shift_unit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [31:0] in_data = 32'd0;
  logic [4:0]  in_amt = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  shift_unit_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // lat = edges after the accept edge until out_valid is seen (1 single-pass, 2 two-pass).
  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a,
                              input logic [31:0] e, input logic err, input int lat);
    vec_t v;
    v.op = op; v.data = d; v.amt = a; v.exp_data = e; v.exp_err = err; v.exp_lat = lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    chk($sformatf("v%0d_in_ready_idle", idx), 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = v.op; in_data = v.data; in_amt = v.amt;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 3'($urandom_range(7, 0)); in_data = $urandom; in_amt = 5'($urandom_range(31, 0));
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_data", idx), out_data, v.exp_data);
    chk($sformatf("v%0d_err", idx), 32'(out_err), 32'(v.exp_err));
    chk($sformatf("v%0d_in_ready_done", idx), 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("v%0d_out_valid_after", idx), 32'(out_valid), 32'd0);
    chk($sformatf("v%0d_in_ready_after", idx), 32'(in_ready), 32'd1);
    $display("vec %0d op=%0d data=0x%08h amt=%0d -> lat=%0d out=0x%08h err=%0b", idx, v.op, v.data,
             v.amt, lat, v.exp_data, v.exp_err);
  endtask

  // Hold in_valid and out_ready high and measure the spacing between accepts.
  task automatic thru(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a,
                      input logic [31:0] e, input int gap, input string tag);
    int acc[$];
    int bad_data;
    int k;
    logic pr;
    bad_data = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_op = op; in_data = d; in_amt = a;
    for (int ed = 0; ed < 14; ed++) begin
      pr = in_ready;
      @(posedge clk); #1;
      if (pr) acc.push_back(ed);
      if (out_valid && out_data !== e) bad_data++;
    end
    in_valid = 1'b0;
    k = 0;
    while (!in_ready && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b0;
    chk({tag, "_accepts"}, 32'(acc.size() >= 3), 32'd1);
    if (acc.size() >= 3) begin
      chk({tag, "_gap1"}, 32'(acc[1] - acc[0]), 32'(gap));
      chk({tag, "_gap2"}, 32'(acc[2] - acc[1]), 32'(gap));
    end
    chk({tag, "_data"}, 32'(bad_data), 32'd0);
    chk({tag, "_drained"}, 32'(in_ready), 32'd1);
    $display("thru %s: %0d accepts in 14 cycles, required spacing %0d", tag, acc.size(), gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int seen;
    logic [31:0] held;

    vecs.push_back(mk(3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1));
    vecs.push_back(mk(3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1));
    vecs.push_back(mk(3'd0, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 1'b0, 1));
    vecs.push_back(mk(3'd0, 32'hF0F0_F0F0, 5'd4,  32'h0F0F_0F00, 1'b0, 1));
    vecs.push_back(mk(3'd1, 32'hF0F0_F0F0, 5'd4,  32'h0F0F_0F0F, 1'b0, 1));
    vecs.push_back(mk(3'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 2));
    vecs.push_back(mk(3'd2, 32'h4000_0000, 5'd4,  32'h0400_0000, 1'b0, 2));
    vecs.push_back(mk(3'd2, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 1'b0, 2));
    vecs.push_back(mk(3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 2));
    vecs.push_back(mk(3'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0, 2));
    vecs.push_back(mk(3'd7, 32'h0000_1234, 5'd3,  32'h0000_0000, 1'b1, 1));
    vecs.push_back(mk(3'd5, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 1'b1, 1));
    vecs.push_back(mk(3'd6, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1));
`ifdef SHIFT_UNIT_CTRL_ROTATE_EN
    vecs.push_back(mk(3'd3, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0, 2));
    vecs.push_back(mk(3'd4, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0, 2));
    vecs.push_back(mk(3'd3, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1));
    vecs.push_back(mk(3'd4, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0, 2));
    vecs.push_back(mk(3'd3, 32'h1234_5678, 5'd31, 32'h091A_2B3C, 1'b0, 2));
`else
    vecs.push_back(mk(3'd3, 32'h8000_0001, 5'd4,  32'h0000_0000, 1'b1, 1));
    vecs.push_back(mk(3'd4, 32'h0000_0001, 5'd1,  32'h0000_0000, 1'b1, 1));
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    thru(3'd0, 32'h0000_0003, 5'd2, 32'h0000_000C, 3, "thru_sll");
    thru(3'd2, 32'h8000_0000, 5'd1, 32'hC000_0000, 4, "thru_sra");

    // Backpressure: DONE held while in_* toggle underneath.
    in_valid = 1'b1; in_op = 3'd0; in_data = 32'h0000_0003; in_amt = 5'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    held = out_data;
    chk("bp_data", held, 32'h0000_0030);
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid; in_data = $urandom; in_op = 3'($urandom_range(4, 0));
      @(posedge clk); #1;
      chk($sformatf("bp_c%0d_data", c), out_data, 32'h0000_0030);
      chk($sformatf("bp_c%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp_c%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (busy || out_valid) seen++;
    end
    chk("bp_no_second_accept", 32'(seen), 32'd0);
    $display("backpressure: held 0x%08h for 5 stalled cycles", held);

    // Reset pulse in PASS2 of an SRA.
    in_valid = 1'b1; in_op = 3'd2; in_data = 32'h8000_0000; in_amt = 5'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ra_busy_pass2", 32'(busy), 32'd1);
    chk("ra_valid_pass2", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("ra_out_valid", 32'(out_valid), 32'd0);
    chk("ra_busy", 32'(busy), 32'd0);
    chk("ra_in_ready", 32'(in_ready), 32'd1);
    chk("ra_out_data", out_data, 32'd0);
    chk("ra_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    out_ready = 1'b0;
    chk("ra_no_stale", 32'(seen), 32'd0);
    $display("reset abort: SRA discarded, %0d stale cycles", seen);
    run_vec(mk(3'd0, 32'h0000_0101, 5'd8, 32'h0001_0100, 1'b0, 1), 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
